shift_sequencer: RTL and testbench

Multi-cycle shift controller that drives the 5-way one-hot `barrelShifter` datapath (±2 positions per pass) to realise arbitrary logical shifts of −8..+7 positions on an 8-bit word. It accepts a word and a signed shift amount over a valid/ready handshake. It decomposes the amount into a sequence of barrel-shifter passes, feeding each pass's `Op` back as the next pass's `Ip`, and returns the result over a second valid/ready handshake. It sits between the issuing pipeline stage and the shared `barrelShifter` instance.

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 94 +++++++++
 tb/tb_shift_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake and barrel-shifter bus for shift_sequencer.
// The slave side is the sequencer. The master side is the issuing stage together with the shared barrelShifter.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [0:WIDTH-1]     in_data;
  logic [AMT_W-1:0]     in_amt;

  logic [0:WIDTH-1]     bs_ip;
  logic [0:4]           bs_shift_mag;
  logic [0:WIDTH-1]     bs_op;

  logic                 out_valid;
  logic                 out_ready;
  logic [0:WIDTH-1]     out_data;

  modport master (
    output in_valid, in_data, in_amt, bs_op, out_ready,
    input  in_ready, bs_ip, bs_shift_mag, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, bs_op, out_ready,
    output in_ready, bs_ip, bs_shift_mag, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Breaks a signed shift of -8..+7 into passes of at most +/-2 through the shared barrelShifter.
// Each pass feeds the previous result back into the shifter, and the final word is returned over a valid/ready handshake.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic signed [AMT_W:0] STEP_P2 = (AMT_W+1)'(2);
  localparam logic signed [AMT_W:0] STEP_P1 = (AMT_W+1)'(1);
  localparam logic signed [AMT_W:0] STEP_N2 = -STEP_P2;
  localparam logic signed [AMT_W:0] STEP_N1 = -STEP_P1;

  localparam logic [0:4] MAG_R2   = 5'b10000;
  localparam logic [0:4] MAG_R1   = 5'b01000;
  localparam logic [0:4] MAG_NONE = 5'b00100;
  localparam logic [0:4] MAG_L1   = 5'b00010;
  localparam logic [0:4] MAG_L2   = 5'b00001;

  state_t                  state;
  logic [0:WIDTH-1]        acc;
  logic signed [AMT_W:0]   rem;
  logic signed [AMT_W:0]   step;
  logic signed [AMT_W:0]   rem_next;
  logic [0:4]              step_code;

  // Take full 2-position passes first, so a leftover single position is always issued last
  always_comb begin
    step      = '0;
    step_code = MAG_NONE;
    if (rem >= STEP_P2) begin
      step      = STEP_P2;
      step_code = MAG_L2;
    end else if (rem == STEP_P1) begin
      step      = STEP_P1;
      step_code = MAG_L1;
    end else if (rem <= STEP_N2) begin
      step      = STEP_N2;
      step_code = MAG_R2;
    end else if (rem == STEP_N1) begin
      step      = STEP_N1;
      step_code = MAG_R1;
    end
    rem_next = rem - step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc   <= bus.in_data;
            rem   <= {bus.in_amt[AMT_W-1], bus.in_amt};
            state <= (bus.in_amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc <= bus.bs_op;
          rem <= rem_next;
          if (rem_next == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything below is decoded from registered state only, so no input reaches an output combinationally except reset into in_ready
  assign bus.in_ready     = (state == IDLE) && !rst;
  assign bus.out_valid    = (state == DONE);
  assign bus.out_data     = acc;
  assign bus.bs_ip        = acc;
  assign bus.bs_shift_mag = (state == SHIFT) ? step_code : MAG_NONE;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer. It models the shared barrelShifter and compares results, pass codes and latency
// against a shift-arithmetic reference. The checks cover a fixed vector table, random operations and two multi-cycle corner sequences.
module tb_shift_sequencer;

  logic clk;
  logic rst;
  int   checks_total;
  int   checks_passed;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational barrelShifter stand-in: logical shifts with zero fill, bit 0 is the MSB
  always_comb begin
    case (bus.bs_shift_mag)
      5'b00001: bus.bs_op = bus.bs_ip << 2;
      5'b00010: bus.bs_op = bus.bs_ip << 1;
      5'b01000: bus.bs_op = bus.bs_ip >> 1;
      5'b10000: bus.bs_op = bus.bs_ip >> 2;
      default:  bus.bs_op = bus.bs_ip;
    endcase
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full request/response transaction, checked against the reference computed from the shift rules
  task automatic applyStimulus(input logic [0:7] data, input logic [3:0] amt, input int hold, input string tag);
    logic [0:7]  exp_out;
    logic [31:0] exp_pack;
    logic [31:0] got_pack;
    int          exp_passes;
    int          got_passes;
    int          a;
    int          mag;
    int          lat;
    int          wait_cnt;
    logic        ready_busy;

    a   = int'($signed(amt));
    mag = (a < 0) ? -a : a;
    exp_out    = (a >= 0) ? (data << a) : (data >> (-a));
    exp_pack   = '0;
    exp_passes = 0;
    while (mag >= 2) begin
      exp_pack = (exp_pack << 5) | ((a > 0) ? 32'b00001 : 32'b10000);
      exp_passes++;
      mag -= 2;
    end
    if (mag == 1) begin
      exp_pack = (exp_pack << 5) | ((a > 0) ? 32'b00010 : 32'b01000);
      exp_passes++;
    end

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_amt    = amt;
    bus.out_ready = 1'b0;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput({tag, ".accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;

    lat        = 0;
    got_pack   = '0;
    got_passes = 0;
    ready_busy = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      got_pack   = (got_pack << 5) | 32'(bus.bs_shift_mag);
      got_passes++;
      ready_busy = ready_busy | bus.in_ready;
    end

    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_passes + 1));
    checkOutput({tag, ".passes"}, 32'(got_passes), 32'(exp_passes));
    checkOutput({tag, ".codes"}, got_pack, exp_pack);
    checkOutput({tag, ".busy_ready"}, 32'(ready_busy), 32'd0);
    checkOutput({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_out));
    checkOutput({tag, ".done_mag"}, 32'(bus.bs_shift_mag), 32'b00100);
    checkOutput({tag, ".done_ready"}, 32'(bus.in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, ".hold_data"}, 32'(bus.out_data), 32'(exp_out));
      checkOutput({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      checkOutput({tag, ".hold_mag"}, 32'(bus.bs_shift_mag), 32'b00100);
    end

    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".after_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".after_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  typedef struct {
    logic [0:7] data;
    logic [3:0] amt;
    logic [0:7] exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int valid_seen;

    checks_total  = 0;
    checks_passed = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'b1010_1101, 4'sd2,   8'b1011_0100, 2};
    vecs[1] = '{8'b1010_1101, 4'hE,    8'b0010_1011, 2};
    vecs[2] = '{8'b1010_1101, 4'sd5,   8'b1010_0000, 4};
    vecs[3] = '{8'b1010_1101, 4'hD,    8'b0001_0101, 3};
    vecs[4] = '{8'b1111_1111, 4'h8,    8'b0000_0000, 5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset.bs_mag", 32'(bus.bs_shift_mag), 32'b00100);
    checkOutput("reset.bs_ip", 32'(bus.bs_ip), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset.release_ready", 32'(bus.in_ready), 32'd1);

    // Fixed vectors: the reference model checks codes, and the table pins the absolute result and latency
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].amt, 0, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].data;
      bus.in_amt   = vecs[i].amt;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int k = 1; k <= vecs[i].exp_lat; k++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          checkOutput($sformatf("table%0d.lat", i), 32'(k), 32'(vecs[i].exp_lat));
          break;
        end
        if (k == vecs[i].exp_lat) begin
          checkOutput($sformatf("table%0d.lat", i), 32'(k + 1), 32'(vecs[i].exp_lat));
        end
      end
      checkOutput($sformatf("table%0d.data", i), 32'(bus.out_data), 32'(vecs[i].exp_out));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end

    // Zero shift with the consumer stalling for three cycles
    applyStimulus(8'h5C, 4'd0, 3, "zero_hold");

    // Reset during the second pass of +5 must abandon the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'b1010_1101;
    bus.in_amt   = 4'sd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid.pass1_mag", 32'(bus.bs_shift_mag), 32'b00001);
    @(negedge clk);
    checkOutput("rst_mid.pass2_mag", 32'(bus.bs_shift_mag), 32'b00001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid.bs_mag", 32'(bus.bs_shift_mag), 32'b00100);
    checkOutput("rst_mid.out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_mid.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid.idle_ready", 32'(bus.in_ready), 32'd1);
    valid_seen = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) valid_seen++;
    end
    bus.out_ready = 1'b0;
    checkOutput("rst_mid.no_result", 32'(valid_seen), 32'd0);

    // Random operations against the reference model
    for (int r = 0; r < 40; r++) begin
      applyStimulus(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
